// File: rtl/spike_pkg.sv
// Shared constants, width helpers and result record for the multi-channel spike detector.
// The optional refractory logic elsewhere is controlled by SPIKE_REFRACTORY_EN.
package spike_pkg;

    localparam int DEF_NCH      = 4;
    localparam int DEF_XW       = 11;
    localparam int DEF_REFRACT  = 8;
    localparam int DEF_THR_INIT = 200;

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Emphasis and threshold carry one extra bit so a full-scale difference cannot overflow.
    function automatic int thr_w(input int xw);
        return xw + 1;
    endfunction

    function automatic int refr_w(input int refract);
        return (refract > 0) ? $clog2(refract + 1) : 1;
    endfunction

    typedef struct packed {
        logic [chan_w(DEF_NCH)-1:0]        ch;
        logic signed [thr_w(DEF_XW)-1:0]   q;
        logic                              spike;
    } spike_res_t;

endpackage

// File: rtl/spike_chan_state.sv
// Per-channel register file: sample history, primed flag, threshold and (with
// SPIKE_REFRACTORY_EN) refractory counter, with one read/update port and a threshold write port.
module spike_chan_state
    import spike_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int XW       = DEF_XW,
    parameter int CHW      = chan_w(NCH),
    parameter int THR_INIT = DEF_THR_INIT
`ifdef SPIKE_REFRACTORY_EN
    ,
    parameter int RW       = refr_w(DEF_REFRACT)
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHW-1:0]       rd_ch_i,
    output logic signed [XW-1:0] rd_last_o,
    output logic                 rd_primed_o,
    output logic signed [XW:0]   rd_thr_o,
`ifdef SPIKE_REFRACTORY_EN
    output logic [RW-1:0]        rd_refr_o,
    input  logic [RW-1:0]        upd_refr_i,
`endif
    input  logic                 upd_en_i,
    input  logic signed [XW-1:0] upd_last_i,
    input  logic                 thr_we_i,
    input  logic [CHW-1:0]       thr_ch_i,
    input  logic signed [XW:0]   thr_val_i
);

    localparam int QW = XW + 1;
    localparam logic signed [QW-1:0] THR_RST = QW'(THR_INIT);

    logic signed [XW-1:0] last_q [NCH];
    logic signed [QW-1:0] thr_q  [NCH];
    logic [NCH-1:0]       primed_q;
`ifdef SPIKE_REFRACTORY_EN
    logic [RW-1:0]        refr_q [NCH];
`endif

    // Combinational read so a same-channel sample on the next cycle sees this cycle's update.
    always_comb begin
        rd_last_o   = '0;
        rd_primed_o = 1'b0;
        rd_thr_o    = '0;
`ifdef SPIKE_REFRACTORY_EN
        rd_refr_o   = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch_i == CHW'(i)) begin
                rd_last_o   = last_q[i];
                rd_primed_o = primed_q[i];
                rd_thr_o    = thr_q[i];
`ifdef SPIKE_REFRACTORY_EN
                rd_refr_o   = refr_q[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                last_q[i] <= '0;
                thr_q[i]  <= THR_RST;
`ifdef SPIKE_REFRACTORY_EN
                refr_q[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (upd_en_i && upd_ch_match(i)) begin
                    last_q[i]   <= upd_last_i;
                    primed_q[i] <= 1'b1;
`ifdef SPIKE_REFRACTORY_EN
                    refr_q[i]   <= upd_refr_i;
`endif
                end
                if (thr_we_i && thr_ch_i == CHW'(i)) begin
                    thr_q[i] <= thr_val_i;
                end
            end
        end
    end

    function automatic logic upd_ch_match(input int idx);
        return rd_ch_i == CHW'(idx);
    endfunction

endmodule

// File: rtl/spike_detect_mc.sv
// Time-multiplexed spike detector: first-difference emphasis against a per-channel threshold,
// one registered result per accepted sample. Refractory suppression enabled by SPIKE_REFRACTORY_EN.
module spike_detect_mc
    import spike_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int XW       = DEF_XW,
    parameter int REFRACT  = DEF_REFRACT,
    parameter int THR_INIT = DEF_THR_INIT,
    parameter int CHW      = chan_w(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [XW-1:0] in_x,
    input  logic                 thr_we,
    input  logic [CHW-1:0]       thr_ch,
    input  logic signed [XW:0]   thr_val,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic signed [XW:0]   out_q,
    output logic                 out_spike
);

    localparam int QW = thr_w(XW);
    localparam int RW = refr_w(REFRACT);

    typedef struct packed {
        logic [CHW-1:0]       ch;
        logic signed [QW-1:0] q;
        logic                 spike;
    } res_t;

    logic                 accept;
    logic signed [XW-1:0] last_rd;
    logic                 primed_rd;
    logic signed [QW-1:0] thr_rd;
    logic signed [QW-1:0] diff;
    logic                 over_thr;
    res_t                 res_d, res_q;
    logic                 valid_d, valid_q;
`ifdef SPIKE_REFRACTORY_EN
    logic [RW-1:0]        refr_rd;
    logic [RW-1:0]        refr_new;
`endif

    spike_chan_state #(
        .NCH      (NCH),
        .XW       (XW),
        .CHW      (CHW),
        .THR_INIT (THR_INIT)
`ifdef SPIKE_REFRACTORY_EN
        ,
        .RW       (RW)
`endif
    ) u_state (
        .clk         (clk),
        .rst         (rst),
        .rd_ch_i     (in_ch),
        .rd_last_o   (last_rd),
        .rd_primed_o (primed_rd),
        .rd_thr_o    (thr_rd),
`ifdef SPIKE_REFRACTORY_EN
        .rd_refr_o   (refr_rd),
        .upd_refr_i  (refr_new),
`endif
        .upd_en_i    (accept),
        .upd_last_i  (in_x),
        .thr_we_i    (thr_we),
        .thr_ch_i    (thr_ch),
        .thr_val_i   (thr_val)
    );

    always_comb begin
        accept   = in_valid && (int'(in_ch) < NCH);
        diff     = {in_x[XW-1], in_x} - {last_rd[XW-1], last_rd};
        res_d.ch = in_ch;
        res_d.q  = primed_rd ? diff : '0;
        over_thr = res_d.q > thr_rd;
`ifdef SPIKE_REFRACTORY_EN
        // A pending refractory window masks the spike and counts down regardless of enable.
        res_d.spike = enable && over_thr && (refr_rd == '0);
        if (refr_rd != '0) begin
            refr_new = refr_rd - 1'b1;
        end else if (res_d.spike) begin
            refr_new = RW'(REFRACT);
        end else begin
            refr_new = '0;
        end
`else
        res_d.spike = enable && over_thr;
`endif
        valid_d = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_ch    = res_q.ch;
    assign out_q     = res_q.q;
    assign out_spike = res_q.spike;

endmodule

// File: tb/tb_spike_detect_mc.sv
// Self-checking bench for spike_detect_mc: directed scenarios plus randomized traffic against a
// per-channel behavioural model.
module tb_spike_detect_mc;

    localparam int NCH     = 5;
    localparam int XW      = 11;
    localparam int REFRACT = 3;
    localparam int CHW     = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b1;
    logic                 in_valid = 1'b0;
    logic [CHW-1:0]       in_ch = '0;
    logic signed [XW-1:0] in_x = '0;
    logic                 thr_we = 1'b0;
    logic [CHW-1:0]       thr_ch = '0;
    logic signed [XW:0]   thr_val = '0;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic signed [XW:0]   out_q;
    logic                 out_spike;

    int checks = 0;
    int errors = 0;

    spike_detect_mc #(
        .NCH      (NCH),
        .XW       (XW),
        .REFRACT  (REFRACT),
        .THR_INIT (200),
        .CHW      (CHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_x      (in_x),
        .thr_we    (thr_we),
        .thr_ch    (thr_ch),
        .thr_val   (thr_val),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_q     (out_q),
        .out_spike (out_spike)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel history, threshold and refractory count as plain integers.
    int m_last [NCH];
    bit m_primed [NCH];
    int m_thr [NCH];
    int m_refr [NCH];
    int exp_valid = 0, exp_ch = 0, exp_q = 0, exp_spike = 0;

    always @(posedge clk) begin
        int c, q;
        bit spk;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_last[i] = 0; m_primed[i] = 0; m_thr[i] = 200; m_refr[i] = 0;
            end
            exp_valid = 0; exp_ch = 0; exp_q = 0; exp_spike = 0;
        end else begin
            exp_valid = 0;
            if (in_valid && int'(in_ch) < NCH) begin
                c = int'(in_ch);
                q = m_primed[c] ? (int'(in_x) - m_last[c]) : 0;
                spk = enable && (q > m_thr[c]);
`ifdef SPIKE_REFRACTORY_EN
                if (m_refr[c] > 0) begin
                    spk = 0;
                    m_refr[c] = m_refr[c] - 1;
                end else if (spk) begin
                    m_refr[c] = REFRACT;
                end
`endif
                m_last[c] = int'(in_x);
                m_primed[c] = 1;
                exp_valid = 1; exp_ch = c; exp_q = q; exp_spike = int'(spk);
            end
            if (thr_we && int'(thr_ch) < NCH) m_thr[int'(thr_ch)] = int'(thr_val);
        end
        #1;
        check("valid", int'(out_valid), exp_valid);
        check("ch", int'(out_ch), exp_ch);
        check("q", int'(out_q), exp_q);
        check("spike", int'(out_spike), exp_spike);
        $display("cyc t=%0t v=%0d ch=%0d q=%0d spike=%0d", $time, out_valid, out_ch, out_q, out_spike);
    end

    // Present one sample for one cycle; outputs for it are visible on return.
    task automatic send(input int ch, input int x);
        in_valid = 1'b1;
        in_ch = CHW'(ch);
        in_x = XW'(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int rx;
    initial begin
        idle(2);
        check("rst_valid", int'(out_valid), 0);
        check("rst_q", int'(out_q), 0);
        check("rst_spike", int'(out_spike), 0);
        rst = 1'b0;
        idle(1);

        send(0, 0);   check("c0_q0", int'(out_q), 0);   check("c0_s0", int'(out_spike), 0);
        send(0, 100); check("c0_q1", int'(out_q), 100); check("c0_s1", int'(out_spike), 0);
        send(0, 350); check("c0_q2", int'(out_q), 250); check("c0_s2", int'(out_spike), 1);
        idle(1);      check("c0_pulse", int'(out_valid), 0);

        send(2, 500); check("c2_q0", int'(out_q), 0);   check("c2_s0", int'(out_spike), 0);
        send(2, 900); check("c2_q1", int'(out_q), 400); check("c2_s1", int'(out_spike), 1);

        send(3, 0);
        thr_we = 1'b1; thr_ch = 3'd3; thr_val = 12'sd50;
        send(3, 100); check("thr_old_q", int'(out_q), 100); check("thr_old_s", int'(out_spike), 0);
        thr_we = 1'b0;
        send(3, 200); check("thr_new_s", int'(out_spike), 1);

        send(0, 400); check("il_q0", int'(out_q), 50);
        send(1, 10);  check("il_q1", int'(out_q), 0);
        send(0, 450); check("il_q2", int'(out_q), 50);
        send(1, 30);  check("il_q3", int'(out_q), 20); check("il_ch3", int'(out_ch), 1);
        send(NCH, 5); check("bad_ch", int'(out_valid), 0);

        enable = 1'b0;
        send(0, 850); check("en0_q", int'(out_q), 400); check("en0_s", int'(out_spike), 0);
        enable = 1'b1;

        rst = 1'b1;
        send(0, 100); check("mid_rst_v", int'(out_valid), 0); check("mid_rst_q", int'(out_q), 0);
        rst = 1'b0;
        send(0, 77);  check("post_rst_q", int'(out_q), 0);

        // Steady +300 steps on ch1: spikes on samples 2 and 6 when refractory is built in.
        for (int k = 0; k < 6; k++) begin
            send(1, -1000 + 300 * k);
            if (k > 0) check("refr_q", int'(out_q), 300);
`ifdef SPIKE_REFRACTORY_EN
            check("refr_s", int'(out_spike), (k == 1 || k == 5) ? 1 : 0);
`else
            check("refr_s", int'(out_spike), (k > 0) ? 1 : 0);
`endif
        end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_ch = CHW'($urandom_range(0, 6));
            rx = int'($urandom_range(0, 2047)) - 1024;
            in_x = XW'(rx);
            thr_we = ($urandom_range(0, 9) == 0);
            thr_ch = CHW'($urandom_range(0, 7));
            rx = int'($urandom_range(0, 700)) - 200;
            thr_val = 12'(rx);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; thr_we = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
